// File: rtl/quan_pkg.sv
// quan_pkg: shared constants and types for the requantization stage.
// Used by quan_requant and quan_round_clamp.
package quan_pkg;

  localparam int QMIN      = -128;
  localparam int QMAX      = 127;
  localparam int Q31_SHIFT = 31;
  localparam int QUAN_LAT  = 4;
  localparam int QACC_W    = 32;
  localparam int QLEN_W    = 20;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } quan_state_t;

  typedef struct packed {
    logic signed [QACC_W-1:0] bias;
    logic [30:0]              mult;
    logic [3:0]               shift;
    logic signed [7:0]        zp;
    logic [QLEN_W-1:0]        len;
  } quan_cfg_t;

endpackage

// File: rtl/quan_round_clamp.sv
// quan_round_clamp: pipeline stages S3 (round-half-up right shift by 31+shift)
// and S4 (zero-point add, clamp to int8, output register).
// Build option QUAN_RELU_EN: lower clamp bound becomes the zero point (fused ReLU).
import quan_pkg::*;

module quan_round_clamp #(
  parameter int P_W = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_vld,
  input  logic [P_W-1:0] i_prod,
  input  logic [3:0]     i_shift,
  input  logic [7:0]     i_zp,
  output logic           o_vld,
  output logic [7:0]     o_data
);

  // One extra bit of headroom so adding the rounding constant cannot wrap.
  function automatic logic signed [P_W:0] round_shr(input logic signed [P_W:0] p,
                                                    input logic [5:0] sh);
    logic signed [P_W:0] half;
    half = (P_W+1)'(1) << (sh - 6'd1);
    return (p + half) >>> sh;
  endfunction

  function automatic logic signed [7:0] clamp8(input logic signed [P_W+1:0] y,
                                               input logic signed [7:0] lo);
    logic signed [P_W+1:0] lo_x;
    logic signed [P_W+1:0] hi_x;
    lo_x = (P_W+2)'(lo);
    hi_x = (P_W+2)'(QMAX);
    if (y > hi_x)      return 8'(QMAX);
    else if (y < lo_x) return lo;
    else               return y[7:0];
  endfunction

  logic [5:0]            w_sh;
  logic signed [P_W:0]   w_prod_x;
  logic signed [P_W+1:0] w_y;
  logic signed [7:0]     w_lo;
  logic signed [P_W:0]   r_r_p2;
  logic                  r_vld_p2;

  assign w_sh     = 6'(Q31_SHIFT) + {2'b00, i_shift};
  assign w_prod_x = (P_W+1)'($signed(i_prod));
  assign w_y      = (P_W+2)'(r_r_p2) + (P_W+2)'($signed(i_zp));

`ifdef QUAN_RELU_EN
  assign w_lo = $signed(i_zp);
`else
  assign w_lo = 8'(QMIN);
`endif

  // S3: rounding arithmetic shift of the full-precision product
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p2 <= 1'b0;
      r_r_p2   <= '0;
    end else begin
      r_vld_p2 <= i_vld;
      r_r_p2   <= round_shr(w_prod_x, w_sh);
    end
  end

  // S4: zero-point add and int8 saturation into the output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_vld  <= 1'b0;
      o_data <= '0;
    end else begin
      o_vld  <= r_vld_p2;
      o_data <= clamp8(w_y, w_lo);
    end
  end

endmodule

// File: rtl/quan_requant.sv
// quan_requant: per-channel requantization ahead of ot_top.
// Run FSM, input/output counters, S1 (bias add) and S2 (Q31 multiply) live
// here; S3/S4 are in quan_round_clamp. Optional build macro: QUAN_RELU_EN.
import quan_pkg::*;

module quan_requant #(
  parameter int ACC_W = 32,
  parameter int LEN_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  input  logic [ACC_W-1:0] cfg_bias,
  input  logic [30:0]      cfg_mult,
  input  logic [3:0]       cfg_shift,
  input  logic [7:0]       cfg_zp,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             valid_in,
  input  logic [ACC_W-1:0] acc_in,
  output logic             valid_out,
  output logic [7:0]       data_out,
  output logic             last_out,
  output logic             busy,
  output logic             drop_err
);

  localparam int P_W = ACC_W + 32;

  quan_state_t         r_st;
  quan_state_t         w_st_nxt;
  quan_cfg_t           r_cfg;
  quan_cfg_t           w_cfg_in;
  logic [LEN_W-1:0]    r_in_cnt;
  logic [LEN_W-1:0]    r_out_cnt;
  logic [LEN_W-1:0]    w_len;
  logic                w_cfg_ok;
  logic                w_acc_ok;
  logic                w_last;
  logic                r_drop_err;
  logic signed [ACC_W:0] r_s1_p0;
  logic                r_vld_p0;
  logic signed [P_W-1:0] r_prod_p1;
  logic                r_vld_p1;
  logic                w_vld_out;
  logic [7:0]          w_data_out;

  // Pack the incoming configuration into the latched form.
  always_comb begin
    w_cfg_in       = '0;
    w_cfg_in.bias  = QACC_W'($signed(cfg_bias));
    w_cfg_in.mult  = cfg_mult;
    w_cfg_in.shift = cfg_shift;
    w_cfg_in.zp    = $signed(cfg_zp);
    w_cfg_in.len   = QLEN_W'(cfg_len);
  end

  assign w_len    = LEN_W'(r_cfg.len);
  assign w_cfg_ok = (r_st == ST_IDLE) && cfg_valid && (cfg_len != '0);
  assign w_acc_ok = (r_st == ST_RUN) && valid_in && (r_in_cnt < w_len);
  // Run ends on the output side so the pipeline always drains fully.
  assign w_last   = w_vld_out && (r_st == ST_RUN) && (r_out_cnt == (w_len - LEN_W'(1)));

  // Next-state logic: IDLE -> RUN on a legal config, RUN -> IDLE on last byte.
  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      ST_IDLE: if (w_cfg_ok) w_st_nxt = ST_RUN;
      ST_RUN:  if (w_last)   w_st_nxt = ST_IDLE;
      default: w_st_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_st <= ST_IDLE;
    else       r_st <= w_st_nxt;
  end

  // Config latch, run counters and the sticky drop flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cfg      <= '0;
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      r_drop_err <= 1'b0;
    end else begin
      if (w_cfg_ok) begin
        r_cfg     <= w_cfg_in;
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
      end else begin
        if (w_acc_ok)                        r_in_cnt  <= r_in_cnt + LEN_W'(1);
        if (w_vld_out && (r_st == ST_RUN))   r_out_cnt <= r_out_cnt + LEN_W'(1);
      end
      if ((r_st == ST_IDLE) && valid_in) r_drop_err <= 1'b1;
    end
  end

  // S1: bias add at full width plus one guard bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p0 <= 1'b0;
      r_s1_p0  <= '0;
    end else begin
      r_vld_p0 <= w_acc_ok;
      r_s1_p0  <= (ACC_W+1)'($signed(acc_in)) + (ACC_W+1)'(r_cfg.bias);
    end
  end

  // S2: signed sum times unsigned Q31 multiplier (zero-extended to signed)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p1  <= 1'b0;
      r_prod_p1 <= '0;
    end else begin
      r_vld_p1  <= r_vld_p0;
      r_prod_p1 <= $signed(P_W'(r_s1_p0)) * $signed(P_W'({1'b0, r_cfg.mult}));
    end
  end

  quan_round_clamp #(.P_W(P_W)) u_round_clamp (
    .clk     (clk),
    .reset   (reset),
    .i_vld   (r_vld_p1),
    .i_prod  (r_prod_p1),
    .i_shift (r_cfg.shift),
    .i_zp    (r_cfg.zp),
    .o_vld   (w_vld_out),
    .o_data  (w_data_out)
  );

  assign valid_out = w_vld_out;
  assign data_out  = w_data_out;
  assign last_out  = w_last;
  assign busy      = (r_st == ST_RUN);
  assign drop_err  = r_drop_err;

endmodule

// File: doc/quan_requant.md
# quan_requant

Per-channel requantization stage directly upstream of `ot_top`. Takes 32-bit signed accumulator words from the PE array and adds a bias. Scales the sum with a fixed-point multiplier and a rounding right shift, then adds the output zero point and saturates to int8. Drives the `valid_in`/`data_in` byte stream that `ot_top` packs into 64-bit output words, and flags the final byte of each configured run.

## Interface
- `ACC_W`, 32, accumulator/bias width (signed)
- `LEN_W`, 20, run-length counter width
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `cfg_valid`  in  1  load run configuration (accepted only in IDLE)
- `cfg_bias`  in  ACC_W  signed bias added to every accumulator
- `cfg_mult`  in  31  unsigned Q31 multiplier (value = cfg_mult / 2^31)
- `cfg_shift`  in  4  extra right shift, 0..15
- `cfg_zp`  in  8  signed output zero point
- `cfg_len`  in  LEN_W  bytes in run; 0 is illegal, cfg rejected
- `valid_in`  in  1  accumulator valid, one per cycle max
- `acc_in`  in  ACC_W  signed accumulator
- `valid_out`  out  1  byte valid (to `ot_top.valid_in`)
- `data_out`  out  8  int8 result (to `ot_top.data_in`)
- `last_out`  out  1  high with the cfg_len-th byte
- `busy`  out  1  high in RUN
- `drop_err`  out  1  sticky: valid_in seen while IDLE

## Operation
- FSM: IDLE → RUN on `cfg_valid` with `cfg_len != 0`. Config is latched into internal registers at that edge.
- `cfg_valid` in RUN is ignored. Latched config is unchanged.
- RUN → IDLE on the cycle `last_out` is driven. `busy` is low from the next cycle.
- `valid_in` in IDLE: sample dropped and `drop_err` set. `drop_err` clears only on `reset`.
- In RUN, inputs are accepted while the input counter is below `cfg_len`. Any extra inputs are dropped without an error.
- Arithmetic, full precision, no intermediate saturation:
  - s1 = acc_in + bias (33-bit signed)
  - p = s1 × mult (64-bit signed)
  - sh = 31 + cfg_shift
  - r = (p + 2^(sh-1)) >>> sh, which rounds half toward +∞
  - y = r + zp
  - data_out = clamp(y, −128, 127)
- Output counter increments on each `valid_out`. `last_out` = `valid_out` & (count == cfg_len−1).
- No backpressure; `ot_top` accepts every byte.

## Timing
- Pipeline depth 4: S1 bias add, S2 multiply, S3 round/shift, S4 zero-point add/clamp/register.
- `valid_out` asserts exactly 4 cycles after the edge that samples `valid_in`.
- Throughput is 1 byte per cycle. Bubbles in the input produce identical bubbles in the output.
- The pipeline drains after the last accepted input. FSM exit is tied to the output count, not the input count.
- Reset values: `valid_out`=0, `data_out`=0, `last_out`=0, `busy`=0, `drop_err`=0. All pipeline valids and counters are 0 and the FSM is in IDLE.
- `reset` mid-run discards all in-flight bytes. No `last_out` is issued for that run.
- `cfg_valid` on the same edge as `last_out` is ignored, because the FSM is still in RUN. It must be reissued.

## Configuration
- `QUAN_RELU_EN` defined: lower clamp bound is `cfg_zp` instead of −128, giving a fused ReLU.
- `QUAN_RELU_EN` undefined: lower clamp bound is −128.
- The upper clamp bound is 127 in both builds.

## Structure
- Shared package `quan_pkg`:
  - `QMIN`=−128, `QMAX`=127
  - `Q31_SHIFT`=31
  - pipeline depth constant `QUAN_LAT`=4
  - typedef `quan_cfg_t` {bias, mult, shift, zp, len}
- One sub-module `quan_round_clamp` covers S3+S4 (round, shift, zp add, clamp) as a registered 2-stage unit. The FSM, counters and S1/S2 stay in `quan_requant`.

## Test plan
- Rounding: mult=2^30, shift=0, zp=0, bias=0, len=3; acc 100, 101, −101 back-to-back → bytes 50, 51, −50. The stream is contiguous, `valid_out` starts 4 cycles after the first input, and `last_out` is on −50.
- Saturation: mult=2^30, bias=0, zp=0, len=2; acc 1000, −1000 → 127, −128.
- Bias, zero point and shift: bias=−20, zp=−10, shift=1, mult=2^30, len=1; acc=100 → −10 + 20 = 10. Computation: (80·2^30 + 2^31) >>> 32 = 20, then + (−10).
- ReLU (build with `QUAN_RELU_EN`): zp=−10, mult=2^30, len=1; acc=−100 → −10. Without the macro the same case → −60.
- Protocol, part 1: valid_in in IDLE → `drop_err`=1, no output. cfg_len=0 → `busy` stays 0.
- Protocol, part 2: with len=4, send 6 inputs → exactly 4 outputs, `last_out` on the 4th. A `cfg_valid` during RUN is ignored.
- Reset: assert `reset` 2 cycles into a len=8 run → all outputs 0 immediately and no `last_out`. A new config after release runs normally.
